// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter_pkg
//  Description : Shared funct codes, arbiter state encoding and the
//                funct -> access size / direction decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

  localparam int FUNC_CODE_W = 10;

  // Low four bits of a funct code carry the opcode class.
  localparam logic [3:0] OPC_LOAD  = 4'b0001;
  localparam logic [3:0] OPC_STORE = 4'b0010;

  // {funct7[2:0], funct3, opcode-class}
  localparam logic [FUNC_CODE_W-1:0] FUNC_SB  = {3'b000, 3'b000, OPC_STORE};
  localparam logic [FUNC_CODE_W-1:0] FUNC_SH  = {3'b000, 3'b001, OPC_STORE};
  localparam logic [FUNC_CODE_W-1:0] FUNC_SW  = {3'b000, 3'b010, OPC_STORE};
  localparam logic [FUNC_CODE_W-1:0] FUNC_LB  = {3'b000, 3'b000, OPC_LOAD};
  localparam logic [FUNC_CODE_W-1:0] FUNC_LH  = {3'b000, 3'b001, OPC_LOAD};
  localparam logic [FUNC_CODE_W-1:0] FUNC_LW  = {3'b000, 3'b010, OPC_LOAD};
  localparam logic [FUNC_CODE_W-1:0] FUNC_LBU = {3'b000, 3'b100, OPC_LOAD};
  localparam logic [FUNC_CODE_W-1:0] FUNC_LHU = {3'b000, 3'b101, OPC_LOAD};

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  // size is 1, 2 or 4 bytes; 0 marks an unknown funct code.
  typedef struct packed {
    logic [2:0] size;
    logic       store;
  } acc_info_t;

  function automatic acc_info_t func_decode(input logic [FUNC_CODE_W-1:0] funct);
    acc_info_t info;
    info.size  = 3'd0;
    info.store = 1'b0;
    case (funct)
      FUNC_SB:  begin info.size = 3'd1; info.store = 1'b1; end
      FUNC_SH:  begin info.size = 3'd2; info.store = 1'b1; end
      FUNC_SW:  begin info.size = 3'd4; info.store = 1'b1; end
      FUNC_LB:  info.size = 3'd1;
      FUNC_LBU: info.size = 3'd1;
      FUNC_LH:  info.size = 3'd2;
      FUNC_LHU: info.size = 3'd2;
      FUNC_LW:  info.size = 3'd4;
      default:  info.size = 3'd0;
    endcase
    return info;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_req_check.sv
`default_nettype none
// ============================================================================
//  Module      : ram_req_check
//  Description : Combinational legality check of one RAM access: funct code,
//                direction, alignment and bounds. Returns bad flag and size.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_req_check
  import ram_arbiter_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int FUNCT_W   = 10
) (
  input  logic [FUNCT_W-1:0] funct,
  input  logic               we,
  input  logic [31:0]        addr,
  output logic               bad,
  output logic [2:0]         size
);

  acc_info_t   w_info;
  logic [32:0] w_end;
  logic        w_bad_code;
  logic        w_bad_dir;
  logic        w_bad_align;
  logic        w_bad_range;

  // Decode the funct and evaluate every rejection reason; the end address is
  // formed in 33 bits so an access near 4 GiB cannot wrap back into range.
  always_comb begin
    w_info      = func_decode(funct);
    w_end       = {1'b0, addr} + {30'd0, w_info.size};
    w_bad_code  = (w_info.size == 3'd0);
    w_bad_dir   = (w_info.store != we);
    w_bad_align = ((w_info.size == 3'd2) &  addr[0]) |
                  ((w_info.size == 3'd4) & (addr[1:0] != 2'b00));
    w_bad_range = (w_end > 33'(MEM_BYTES));
    bad         = w_bad_code | w_bad_dir | w_bad_align | w_bad_range;
    size        = w_info.size;
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Two-master round-robin arbiter and 3-cycle access sequencer
//                (IDLE -> ACCESS -> DONE) for the 1 KiB data RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int FUNCT_W   = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               m0_req_i,
  input  logic               m1_req_i,
  input  logic               m0_we_i,
  input  logic               m1_we_i,
  input  logic [FUNCT_W-1:0] m0_funct_i,
  input  logic [FUNCT_W-1:0] m1_funct_i,
  input  logic [31:0]        m0_addr_i,
  input  logic [31:0]        m1_addr_i,
  input  logic [31:0]        m0_wdata_i,
  input  logic [31:0]        m1_wdata_i,
  output logic               m0_gnt_o,
  output logic               m1_gnt_o,
  output logic               m0_done_o,
  output logic               m1_done_o,
  output logic [31:0]        rdata_o,
  output logic               err_o,
  output logic               ram_r_en_o,
  output logic               ram_w_en_o,
  output logic [FUNCT_W-1:0] ram_funct_o,
  output logic [31:0]        ram_addr_o,
  output logic [31:0]        ram_wdata_o,
  input  logic [31:0]        ram_rdata_i
);

  arb_state_t         r_state;
  arb_state_t         w_next;

  logic               r_last;
  logic               r_id;
  logic               r_we;
  logic               r_bad;
  logic [2:0]         r_size;
  logic [FUNCT_W-1:0] r_funct;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;

  logic               w_any;
  logic               w_win;
  logic               w_take;
  logic               w_sel_we;
  logic [FUNCT_W-1:0] w_sel_funct;
  logic [31:0]        w_sel_addr;
  logic [31:0]        w_sel_wdata;
  logic               w_chk_bad;
  logic [2:0]         w_chk_size;
  logic [31:0]        w_wmask;

  // Pick the winner (round-robin on a tie) and mux its request fields.
  always_comb begin
    w_any = m0_req_i | m1_req_i;
    if (m0_req_i & m1_req_i) begin
      w_win = ~r_last;
    end else begin
      w_win = m1_req_i;
    end
    w_take      = (r_state == ARB_IDLE) & w_any & ~rst_i;
    w_sel_we    = w_win ? m1_we_i    : m0_we_i;
    w_sel_funct = w_win ? m1_funct_i : m0_funct_i;
    w_sel_addr  = w_win ? m1_addr_i  : m0_addr_i;
    w_sel_wdata = w_win ? m1_wdata_i : m0_wdata_i;
  end

  ram_req_check #(
    .MEM_BYTES (MEM_BYTES),
    .FUNCT_W   (FUNCT_W)
  ) u_check (
    .funct (w_sel_funct),
    .we    (w_sel_we),
    .addr  (w_sel_addr),
    .bad   (w_chk_bad),
    .size  (w_chk_size)
  );

  // State register; reset returns to IDLE from any state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Keep only the bytes the access actually stores.
  always_comb begin
    case (r_size)
      3'd1:    w_wmask = 32'h0000_00FF;
      3'd2:    w_wmask = 32'h0000_FFFF;
      default: w_wmask = 32'hFFFF_FFFF;
    endcase
  end

  // Next-state and output decode. Enables are also gated by rst_i so that a
  // reset edge which ends ACCESS cannot commit the aborted store.
  always_comb begin
    w_next      = r_state;
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    m0_done_o   = 1'b0;
    m1_done_o   = 1'b0;
    err_o       = 1'b0;
    ram_r_en_o  = 1'b0;
    ram_w_en_o  = 1'b0;
    ram_funct_o = '0;
    ram_addr_o  = 32'd0;
    ram_wdata_o = 32'd0;
    case (r_state)
      ARB_IDLE: begin
        m0_gnt_o = w_take & ~w_win;
        m1_gnt_o = w_take &  w_win;
        if (w_take) begin
          w_next = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        w_next = ARB_DONE;
        if (!r_bad) begin
          ram_r_en_o  = ~r_we & ~rst_i;
          ram_w_en_o  =  r_we & ~rst_i;
          ram_funct_o = r_funct;
          ram_addr_o  = r_addr;
          ram_wdata_o = r_wdata & w_wmask;
        end
      end
      ARB_DONE: begin
        w_next    = ARB_IDLE;
        m0_done_o = ~r_id;
        m1_done_o =  r_id;
        err_o     = r_bad;
      end
      default: begin
        w_next = ARB_IDLE;
      end
    endcase
  end

  // Latch the winning request, capture load data, and advance the RR pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_bad   <= 1'b0;
      r_size  <= 3'd0;
      r_funct <= '0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      if (w_take) begin
        r_id    <= w_win;
        r_we    <= w_sel_we;
        r_bad   <= w_chk_bad;
        r_size  <= w_chk_size;
        r_funct <= w_sel_funct;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (r_state == ARB_ACCESS) begin
        r_rdata <= (!r_bad && !r_we) ? ram_rdata_i : 32'd0;
      end
      if (r_state == ARB_DONE) begin
        r_last <= r_id;
      end
    end
  end

  assign rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Scoreboard bench for ram_arbiter with a byte RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [9:0]  m0_funct, m1_funct;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_done, m1_done, err, r_en, w_en;
  logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;
  logic [9:0]  ram_funct;

  ram_arbiter #(.MEM_BYTES(1024), .FUNCT_W(10)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req), .m1_req_i(m1_req), .m0_we_i(m0_we), .m1_we_i(m1_we),
    .m0_funct_i(m0_funct), .m1_funct_i(m1_funct),
    .m0_addr_i(m0_addr), .m1_addr_i(m1_addr),
    .m0_wdata_i(m0_wdata), .m1_wdata_i(m1_wdata),
    .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt), .m0_done_o(m0_done), .m1_done_o(m1_done),
    .rdata_o(rdata), .err_o(err), .ram_r_en_o(r_en), .ram_w_en_o(w_en),
    .ram_funct_o(ram_funct), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- RAM model (little-endian, funct-aware) ----------------
  logic [7:0] mem [1024];
  logic [9:0] ma;
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    ma = ram_addr[9:0];
    b0 = mem[ma];
    b1 = mem[ma + 10'd1];
    b2 = mem[ma + 10'd2];
    b3 = mem[ma + 10'd3];
    case (ram_funct)
      FUNC_LB:  ram_rdata = {{24{b0[7]}}, b0};
      FUNC_LBU: ram_rdata = {24'd0, b0};
      FUNC_LH:  ram_rdata = {{16{b1[7]}}, b1, b0};
      FUNC_LHU: ram_rdata = {16'd0, b1, b0};
      FUNC_LW:  ram_rdata = {b3, b2, b1, b0};
      default:  ram_rdata = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (w_en) begin
      mem[ma] <= ram_wdata[7:0];
      if (ram_funct == FUNC_SH || ram_funct == FUNC_SW) mem[ma + 10'd1] <= ram_wdata[15:8];
      if (ram_funct == FUNC_SW) begin
        mem[ma + 10'd2] <= ram_wdata[23:16];
        mem[ma + 10'd3] <= ram_wdata[31:24];
      end
    end
  end

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct { logic err; logic [31:0] rdata; bit chk_rd; } exp_t;
  typedef struct { int id; int gap; } gexp_t;
  exp_t  q0[$];
  exp_t  q1[$];
  gexp_t gq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_cyc [2];
  int last_gnt_cyc = 0;
  int wen_cnt = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: compare every grant and completion against the queues.
  always @(negedge clk) begin : mon
    int    id;
    exp_t  e;
    gexp_t g;
    if (w_en) wen_cnt++;
    if (m0_gnt && m1_gnt) chk("dual_gnt", 32'd1, 32'd0);
    if (m0_gnt || m1_gnt) begin
      id = m1_gnt ? 1 : 0;
      if (gq.size() == 0) begin
        chk("unexpected_gnt", 32'(id + 1), 32'd0);
      end else begin
        g = gq.pop_front();
        chk("gnt_id", 32'(id), 32'(g.id));
        if (g.gap != 0) chk("gnt_period", 32'(cyc - last_gnt_cyc), 32'(g.gap));
      end
      last_gnt_cyc = cyc;
      gnt_cyc[id]  = cyc;
    end
    if (m0_done && m1_done) chk("dual_done", 32'd1, 32'd0);
    if (m0_done || m1_done) begin
      id = m1_done ? 1 : 0;
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        chk("unexpected_done", 32'(id + 1), 32'd0);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk("done_latency", 32'(cyc - gnt_cyc[id]), 32'd2);
        chk("done_err", {31'd0, err}, {31'd0, e.err});
        if (e.chk_rd) chk("done_rdata", rdata, e.rdata);
      end
    end
  end

  // ---------------- drivers ----------------
  // Raise a request (fields may change under a held req) and wait for done.
  task automatic do_txn(input int id, input logic we, input logic [9:0] funct,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input bit chk_rd, input bit keep);
    exp_t e;
    bit   seen;
    e.err = exp_err; e.rdata = exp_rd; e.chk_rd = chk_rd;
    if (id == 0) begin
      q0.push_back(e);
      m0_we = we; m0_funct = funct; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end else begin
      q1.push_back(e);
      m1_we = we; m1_funct = funct; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if ((id == 0) ? m0_done : m1_done) seen = 1'b1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    if (!keep) begin
      if (id == 0) m0_req = 1'b0; else m1_req = 1'b0;
    end
  endtask

  task automatic solo(input int id, input logic we, input logic [9:0] funct,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rd, input bit chk_rd);
    gexp_t g;
    g.id = id; g.gap = 0;
    gq.push_back(g);
    do_txn(id, we, funct, addr, wdata, exp_err, exp_rd, chk_rd, 1'b0);
  endtask

  function automatic void push_g(input int id, input int gap);
    gexp_t g;
    g.id = id; g.gap = gap;
    gq.push_back(g);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst_i = 1'b1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_funct = '0; m1_funct = '0; m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {25'd0, m0_gnt, m1_gnt, m0_done, m1_done, err, r_en, w_en}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_ram_funct", {22'd0, ram_funct}, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Tie: both request continuously, grants 0,1,0,1 every 3 cycles.
    push_g(0, 0); push_g(1, 3); push_g(0, 3); push_g(1, 3);
    fork
      begin
        do_txn(0, 1'b1, FUNC_SW, 32'h100, 32'h1111_1111, 1'b0, 32'd0, 1'b0, 1'b1);
        do_txn(0, 1'b1, FUNC_SW, 32'h200, 32'h3333_3333, 1'b0, 32'd0, 1'b0, 1'b0);
      end
      begin
        do_txn(1, 1'b1, FUNC_SW, 32'h100, 32'h2222_2222, 1'b0, 32'd0, 1'b0, 1'b1);
        do_txn(1, 1'b1, FUNC_SW, 32'h204, 32'h4444_4444, 1'b0, 32'd0, 1'b0, 1'b0);
      end
    join
    chk("tie_mem_100", mem_word(32'h100), 32'h2222_2222);
    chk("tie_mem_200", mem_word(32'h200), 32'h3333_3333);
    chk("tie_mem_204", mem_word(32'h204), 32'h4444_4444);

    // Single store then load.
    solo(0, 1'b1, FUNC_SW, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0);
    solo(0, 1'b0, FUNC_LW, 32'h40, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b1);

    // Byte store and sign/zero-extended loads.
    solo(0, 1'b1, FUNC_SB, 32'h5, 32'h1234_5680, 1'b0, 32'd0, 1'b0);
    solo(1, 1'b0, FUNC_LBU, 32'h5, 32'd0, 1'b0, 32'h0000_0080, 1'b1);
    solo(0, 1'b0, FUNC_LW, 32'h4, 32'd0, 1'b0, 32'h0000_8000, 1'b1);
    solo(0, 1'b0, FUNC_LB, 32'h5, 32'd0, 1'b0, 32'hFFFF_FF80, 1'b1);

    // Error cases: no write enable, rdata forced to 0.
    w0 = wen_cnt;
    solo(0, 1'b1, FUNC_SH, 32'h11, 32'hABCD_1234, 1'b1, 32'd0, 1'b1);
    chk("err_sh_no_wen", 32'(wen_cnt - w0), 32'd0);
    chk("err_sh_mem", mem_word(32'h10), 32'd0);
    solo(0, 1'b0, FUNC_LW, 32'd1022, 32'd0, 1'b1, 32'd0, 1'b1);
    solo(1, 1'b0, 10'h3FF, 32'h40, 32'd0, 1'b1, 32'd0, 1'b1);
    solo(0, 1'b0, FUNC_SW, 32'h40, 32'h0, 1'b1, 32'd0, 1'b1);
    solo(0, 1'b0, FUNC_LW, 32'h40, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    solo(1, 1'b0, FUNC_LW, 32'd1020, 32'd0, 1'b0, 32'd0, 1'b1);
    solo(0, 1'b0, FUNC_LHU, 32'h42, 32'd0, 1'b0, 32'h0000_DEAD, 1'b1);

    // Request held after done: re-granted 3 cycles after the first grant.
    push_g(0, 0); push_g(0, 3);
    do_txn(0, 1'b0, FUNC_LW, 32'h40, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    do_txn(0, 1'b0, FUNC_LW, 32'h100, 32'd0, 1'b0, 32'h2222_2222, 1'b1, 1'b0);

    // Reset during ACCESS of an m1 store; then reset with requests pending.
    w0 = wen_cnt;
    push_g(1, 0);
    m1_we = 1'b1; m1_funct = FUNC_SW; m1_addr = 32'h80; m1_wdata = 32'h5555_5555; m1_req = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    m0_we = 1'b0; m0_funct = FUNC_LW; m0_addr = 32'h80; m0_req = 1'b1;
    m1_we = 1'b0; m1_funct = FUNC_LW; m1_addr = 32'h100;
    @(negedge clk);
    chk("rst_req_no_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("abort_mem_80", mem_word(32'h80), 32'd0);
    chk("abort_no_wen", 32'(wen_cnt - w0), 32'd0);
    push_g(0, 0); push_g(1, 3);
    fork
      do_txn(0, 1'b0, FUNC_LW, 32'h80, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
      do_txn(1, 1'b0, FUNC_LW, 32'h100, 32'd0, 1'b0, 32'h2222_2222, 1'b1, 1'b0);
    join

    repeat (4) @(posedge clk);
    chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
    chk("done_queues_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
